// File: rtl/qoi_chunk_packer.sv
// qoi_chunk_packer: turns QOI chunk descriptors into stream bytes, wraps them
// with the 14-byte header and 8-byte end marker, and writes them into the
// circular output buffer without overrunning bytes the CPU has not read yet.
module qoi_chunk_packer #(
    parameter int BUF_DEPTH = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [15:0]                  img_width,
    input  logic [15:0]                  img_height,
    input  logic                         chunk_valid,
    output logic                         chunk_ready,
    input  logic [2:0]                   chunk_op,
    input  logic [31:0]                  chunk_payload,
    input  logic                         flush,
    input  logic                         rd_ack,
    output logic                         buf_we,
    output logic [$clog2(BUF_DEPTH)-1:0] buf_addr,
    output logic [7:0]                   buf_wdata,
    output logic [$clog2(BUF_DEPTH):0]   buf_level,
    output logic [15:0]                  total_bytes,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL = LW'(BUF_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_HEADER, S_ACCEPT, S_EMIT, S_TAIL, S_DONE} state_t;

    // Formatted chunk: b[0] goes out first, n is the byte count (1..5).
    typedef struct packed {
        logic [4:0][7:0] b;
        logic [2:0]      n;
    } chunk_t;

    state_t        state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    chunk_t        ck_q, ck_d;
    logic [15:0]   w_q, w_d, h_q, h_d;
    logic          fp_q, fp_d;
    logic          err_d, we_d, ready_d, busy_d, done_d;
    logic [7:0]    wdata_d;
    logic [AW-1:0] addr_d;
    logic [LW-1:0] lvl_d;
    logic [15:0]   tot_d;
    logic          hs, bad_chunk;

    function automatic chunk_t fmt(input logic [2:0] op, input logic [31:0] p);
        chunk_t c;
        c = '0;
        case (op)
            3'd0: begin c.b[0] = {2'b00, p[5:0]}; c.n = 3'd1; end
            3'd1: begin c.b[0] = {2'b01, p[5:0]}; c.n = 3'd1; end
            3'd2: begin c.b[0] = {2'b10, p[13:8]}; c.b[1] = p[7:0]; c.n = 3'd2; end
            3'd3: begin c.b[0] = {2'b11, p[5:0]}; c.n = 3'd1; end
            3'd4: begin
                c.b[0] = 8'hFE; c.b[1] = p[31:24]; c.b[2] = p[23:16]; c.b[3] = p[15:8];
                c.n = 3'd4;
            end
            3'd5: begin
                c.b[0] = 8'hFF; c.b[1] = p[31:24]; c.b[2] = p[23:16]; c.b[3] = p[15:8];
                c.b[4] = p[7:0]; c.n = 3'd5;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Byte that the given state/index would put on the bus.
    function automatic logic [7:0] byte_at(input state_t st, input logic [3:0] i,
                                           input chunk_t c, input logic [15:0] w,
                                           input logic [15:0] h);
        logic [7:0] v;
        v = 8'h00;
        case (st)
            S_HEADER: begin
                case (i)
                    4'd0:    v = 8'h71;
                    4'd1:    v = 8'h6F;
                    4'd2:    v = 8'h69;
                    4'd3:    v = 8'h66;
                    4'd6:    v = w[15:8];
                    4'd7:    v = w[7:0];
                    4'd10:   v = h[15:8];
                    4'd11:   v = h[7:0];
                    4'd12:   v = 8'h04;
                    default: v = 8'h00;
                endcase
            end
            S_EMIT: begin
                case (i)
                    4'd0:    v = c.b[0];
                    4'd1:    v = c.b[1];
                    4'd2:    v = c.b[2];
                    4'd3:    v = c.b[3];
                    4'd4:    v = c.b[4];
                    default: v = 8'h00;
                endcase
            end
            S_TAIL:  v = (i == 4'd7) ? 8'h01 : 8'h00;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    assign hs        = chunk_valid && chunk_ready;
    assign bad_chunk = (chunk_op > 3'd5) || (chunk_op == 3'd3 && chunk_payload[5:0] >= 6'd62);

    // Next-state logic; outputs are computed from the next state so they can be registered.
    // buf_we already reflects the stall check, so it doubles as "this byte went out".
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ck_d    = ck_q;
        w_d     = w_q;
        h_d     = h_q;
        fp_d    = fp_q;
        err_d   = err;
        addr_d  = buf_addr + AW'(buf_we);
        tot_d   = total_bytes + 16'(buf_we);
        lvl_d   = buf_level + LW'(buf_we) - LW'(rd_ack && (buf_level != '0));
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_HEADER;
                    idx_d   = '0;
                    w_d     = img_width;
                    h_d     = img_height;
                    tot_d   = '0;
                    err_d   = 1'b0;
                    fp_d    = 1'b0;
                end
            end
            S_HEADER: begin
                if (flush) fp_d = 1'b1;
                if (buf_we) begin
                    if (idx_q == 4'd13) begin
                        state_d = S_ACCEPT;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            S_ACCEPT: begin
                if (fp_q) begin
                    state_d = S_TAIL;
                    idx_d   = '0;
                end else if (hs) begin
                    if (flush) fp_d = 1'b1;
                    if (bad_chunk) begin
                        err_d = 1'b1;
                    end else begin
                        ck_d    = fmt(chunk_op, chunk_payload);
                        state_d = S_EMIT;
                        idx_d   = '0;
                    end
                end else if (flush) begin
                    state_d = S_TAIL;
                    idx_d   = '0;
                end
            end
            S_EMIT: begin
                if (flush) fp_d = 1'b1;
                if (buf_we) begin
                    if (idx_q == {1'b0, ck_q.n} - 4'd1) begin
                        state_d = S_ACCEPT;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            S_TAIL: begin
                if (buf_we) begin
                    if (idx_q == 4'd7) begin
                        state_d = S_DONE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        we_d    = (state_d == S_HEADER || state_d == S_EMIT || state_d == S_TAIL) && (lvl_d != FULL);
        wdata_d = byte_at(state_d, idx_d, ck_d, w_d, h_d);
        ready_d = (state_d == S_ACCEPT) && !fp_d;
        busy_d  = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d  = (state_d == S_DONE);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            ck_q        <= '0;
            w_q         <= '0;
            h_q         <= '0;
            fp_q        <= 1'b0;
            err         <= 1'b0;
            buf_we      <= 1'b0;
            buf_wdata   <= '0;
            buf_addr    <= '0;
            buf_level   <= '0;
            total_bytes <= '0;
            chunk_ready <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            ck_q        <= ck_d;
            w_q         <= w_d;
            h_q         <= h_d;
            fp_q        <= fp_d;
            err         <= err_d;
            buf_we      <= we_d;
            buf_wdata   <= wdata_d;
            buf_addr    <= addr_d;
            buf_level   <= lvl_d;
            total_bytes <= tot_d;
            chunk_ready <= ready_d;
            busy        <= busy_d;
            done        <= done_d;
        end
    end
endmodule

// File: doc/qoi_chunk_packer.md
# qoi_chunk_packer

Byte serialiser that sits directly downstream of the QOI encoder core inside the `qoi` accelerator. It accepts one encoded chunk descriptor at a time (op + payload), formats it into 1–5 QOI stream bytes and writes them sequentially into the 1 KiB output buffer that the 65C02 drains through the accelerator memory window. It also emits the 14-byte QOI header on start and the 8-byte end marker on flush, and tracks buffer occupancy so that it never overruns unread data.

## Interface
- BUF_DEPTH, 1024: output buffer depth in bytes; power of two; address width is log2(BUF_DEPTH).
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  one-cycle pulse; begin a new stream (header emission). Honoured only in IDLE or DONE.
- img_width  in  16  image width, sampled on start.
- img_height  in  16  image height, sampled on start.
- chunk_valid  in  1  chunk descriptor valid.
- chunk_ready  out  1  packer can take a chunk this cycle.
- chunk_op  in  3  0 INDEX, 1 DIFF, 2 LUMA, 3 RUN, 4 RGB, 5 RGBA, 6–7 illegal.
- chunk_payload  in  32  op fields (see Operation).
- flush  in  1  one-cycle pulse; append end marker and finish the stream.
- rd_ack  in  1  CPU side consumed one byte from the buffer.
- buf_we  out  1  output buffer write strobe.
- buf_addr  out  10  output buffer write address.
- buf_wdata  out  8  output buffer write data.
- buf_level  out  11  unread bytes in buffer, 0..1024.
- total_bytes  out  16  bytes written since start, modulo 2^16.
- busy  out  1  state is not IDLE/DONE.
- done  out  1  high in DONE.
- err  out  1  sticky illegal-chunk flag; cleared by start or rst.

## Operation
- States: IDLE, HEADER, ACCEPT, EMIT, TAIL, DONE.
- IDLE/DONE --start--> HEADER: latch width/height; clear total_bytes, err, flush_pend; buf_addr and buf_level are NOT cleared (buffer is continuous).
- HEADER: write 71 6F 69 66, 00 00 w[15:8] w[7:0], 00 00 h[15:8] h[7:0], 04, 00 (14 bytes) -> ACCEPT.
- ACCEPT: chunk_ready=1 iff no flush_pend. On handshake latch the formatted bytes and count n -> EMIT. Illegal op, or RUN with payload[5:0] ≥ 62: set err, drop chunk, stay in ACCEPT.
- Formatting: INDEX {00,p[5:0]}; DIFF {01,p[5:0]}; RUN {11,p[5:0]}; LUMA {10,p[13:8]}, p[7:0]; RGB FE, p[31:24], p[23:16], p[15:8]; RGBA FF, p[31:24], p[23:16], p[15:8], p[7:0].
- EMIT: one byte per unstalled cycle; after byte n -> ACCEPT.
- flush in ACCEPT without a chunk handshake -> TAIL. flush coinciding with a handshake, or arriving in HEADER/EMIT, sets flush_pend; ACCEPT with flush_pend goes to TAIL without raising chunk_ready. flush in IDLE/DONE ignored.
- TAIL: write 00 ×7 then 01 -> DONE.
- start while busy: ignored.
- Write: buf_we=1, buf_wdata=byte, buf_addr advances by 1 after each write, wrapping 1023 -> 0. total_bytes increments per write.
- buf_level: +1 on write, −1 on rd_ack; both in the same cycle -> unchanged; rd_ack at level 0 ignored.
- Stall: when buf_level == BUF_DEPTH, no write occurs and the byte pointer/state hold. A simultaneous rd_ack does not unstall in that cycle.

## Timing
- Reset: state IDLE; chunk_ready, buf_we, busy, done, err = 0; buf_addr, buf_level, total_bytes = 0.
- All outputs registered. The start pulse in cycle t produces the first header byte with buf_we high in t+1; the 14 header bytes appear in t+1..t+14 if unstalled; chunk_ready is high from t+15.
- A chunk handshake in cycle t produces byte 1 in t+1 and byte n in t+n; chunk_ready is high again in t+n+1. An n-byte chunk therefore costs n+1 cycles.
- When flush is taken in ACCEPT in cycle t, the tail bytes are written in t+1..t+8, and done is high from t+9.
- Each stall cycle inserts exactly one bubble with buf_we=0.
- rst mid-stream: next cycle all outputs take their reset values, and any partially emitted chunk is discarded.

## Test plan
- Empty stream: start with w=0x0102, h=0x0003, then flush. Required: 22 writes at addresses 0..21: 71 6F 69 66 00 00 01 02 00 00 00 03 04 00 00×7 01. done=1, total_bytes=22, buf_level=22.
- Chunk formats: after the header, send RGBA p=0x11223344, LUMA p=0x2A55, RUN p=5, INDEX p=63. Required bytes: FF 11 22 33 44, AA 55, C5, 3F. chunk_ready is low for 5/2/1/1 cycles respectively.
- Illegal chunks: RUN p=62, then op 7. Required: no writes, err=1 and stays set, chunk_ready stays high. A following DIFF p=0x15 writes 55.
- Backpressure: no rd_ack until the level reaches 1024 mid-RGB. Required: buf_we=0 and the state holds. One rd_ack then releases exactly one byte, and buf_addr wraps 1023 -> 0 with correct data.
- Simultaneous events: flush in the same cycle as an RGB handshake. Required: the 4 RGB bytes are written, then the 8 tail bytes, with chunk_ready never reasserting. rd_ack on a write cycle leaves buf_level unchanged.
- Reset mid-EMIT of RGBA after 2 bytes. Required: the next cycle shows buf_we=0, buf_addr=0, buf_level=0, state IDLE, and no further writes until start.
